// File: rtl/fp16_pkg.sv
// Shared FP16 field layout, special encodings and vector geometry for the
// softmax subtract-max stage.
package fp16_pkg;

    localparam int FP16_SIGN_W = 1;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MANT_W = 10;
    localparam int FP16_BIAS   = 15;

    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
    localparam logic [15:0] FP16_POS_INF = 16'h7C00;
    localparam logic [15:0] FP16_ZERO    = 16'h0000;

    localparam int VEC_N      = 64;
    localparam int VEC_LANES  = 4;
    localparam int VEC_BEATS  = VEC_N / VEC_LANES;
    localparam int BEAT_IDX_W = $clog2(VEC_BEATS);
    localparam int ELEM_IDX_W = $clog2(VEC_N);

    function automatic logic fp16_is_nan(input logic [15:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
    endfunction

    function automatic logic fp16_is_inf(input logic [15:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] == 10'h000);
    endfunction

endpackage

// File: rtl/fp16_sub_max64_if.sv
// Vector-in, max-in and difference-beat-out handshake bundle.
interface fp16_sub_max64_if;
    import fp16_pkg::*;

    logic [VEC_N*16-1:0]     x;
    logic                    x_valid;
    logic                    x_ready;
    logic [15:0]             max;
    logic                    max_valid;
    logic                    max_ready;
    logic [VEC_LANES*16-1:0] d_data;
    logic [BEAT_IDX_W-1:0]   d_idx;
    logic                    d_last;
    logic                    d_valid;
    logic                    d_ready;

    modport slave (
        input  x, x_valid, max, max_valid, d_ready,
        output x_ready, max_ready, d_data, d_idx, d_last, d_valid
    );

    modport master (
        output x, x_valid, max, max_valid, d_ready,
        input  x_ready, max_ready, d_data, d_idx, d_last, d_valid
    );
endinterface

// File: rtl/fp16_sub.sv
// Combinational binary16 a-b with round-to-nearest-even; subnormal inputs
// and results flush to zero.
module fp16_sub
    import fp16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s;
    logic [4:0]  a_exp_s, b_exp_s, big_exp_s, sml_exp_s, exp_diff_s;
    logic [10:0] a_sig_s, b_sig_s, big_sig_s, sml_sig_s;
    logic        swap_s, big_sgn_s, sml_sgn_s;
    logic [3:0]  shamt_s, lead_s, lz_s;
    logic [29:0] sml_wide_s;
    logic [13:0] big_al_s, sml_al_s, norm_s;
    logic [14:0] raw_s;
    logic signed [6:0] exp_norm_s, exp_rnd_s;
    logic        rnd_up_s;
    logic [11:0] sig_rnd_s;
    logic [9:0]  man_s;

    assign a_nan_s = fp16_is_nan(a);
    assign b_nan_s = fp16_is_nan(b);
    assign a_inf_s = fp16_is_inf(a);
    assign b_inf_s = fp16_is_inf(b);

    // Zero-exponent operands become magnitude zero at the minimum exponent.
    assign a_exp_s = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    assign b_exp_s = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    assign a_sig_s = (a[14:10] == 5'd0) ? 11'd0 : {1'b1, a[9:0]};
    assign b_sig_s = (b[14:10] == 5'd0) ? 11'd0 : {1'b1, b[9:0]};

    assign swap_s    = {b_exp_s, b_sig_s} > {a_exp_s, a_sig_s};
    assign big_sgn_s = swap_s ? ~b[15] : a[15];
    assign sml_sgn_s = swap_s ? a[15]  : ~b[15];
    assign big_exp_s = swap_s ? b_exp_s : a_exp_s;
    assign sml_exp_s = swap_s ? a_exp_s : b_exp_s;
    assign big_sig_s = swap_s ? b_sig_s : a_sig_s;
    assign sml_sig_s = swap_s ? a_sig_s : b_sig_s;

    // Align the smaller operand; everything below the round bit folds into sticky.
    assign exp_diff_s = big_exp_s - sml_exp_s;
    assign shamt_s    = (exp_diff_s > 5'd15) ? 4'd15 : exp_diff_s[3:0];
    assign sml_wide_s = {sml_sig_s, 19'd0} >> shamt_s;
    assign sml_al_s   = {sml_wide_s[29:17], sml_wide_s[16] | (|sml_wide_s[15:0])};
    assign big_al_s   = {big_sig_s, 3'd0};
    assign raw_s      = (big_sgn_s == sml_sgn_s) ? ({1'b0, big_al_s} + {1'b0, sml_al_s})
                                                 : ({1'b0, big_al_s} - {1'b0, sml_al_s});

    // Leading-one position of the uncarried magnitude.
    always_comb begin
        lead_s = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (raw_s[i]) begin
                lead_s = 4'(i);
            end else begin
                lead_s = lead_s;
            end
        end
    end

    assign lz_s = 4'd13 - lead_s;

    // Normalize to hidden bit at [13], then apply RNE on guard/round/sticky.
    always_comb begin
        norm_s     = raw_s[13:0];
        exp_norm_s = $signed({2'b00, big_exp_s});
        exp_rnd_s  = exp_norm_s;
        man_s      = 10'd0;
        if (raw_s[14]) begin
            norm_s     = {raw_s[14:2], raw_s[1] | raw_s[0]};
            exp_norm_s = $signed({2'b00, big_exp_s}) + 7'sd1;
        end else begin
            norm_s     = raw_s[13:0] << lz_s;
            exp_norm_s = $signed({2'b00, big_exp_s}) - $signed({3'b000, lz_s});
        end
        rnd_up_s  = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        sig_rnd_s = {1'b0, norm_s[13:3]} + {11'd0, rnd_up_s};
        if (sig_rnd_s[11]) begin
            exp_rnd_s = exp_norm_s + 7'sd1;
            man_s     = sig_rnd_s[10:1];
        end else begin
            exp_rnd_s = exp_norm_s;
            man_s     = sig_rnd_s[9:0];
        end
    end

    // Special operands take precedence over the arithmetic result.
    always_comb begin
        y = {big_sgn_s, exp_rnd_s[4:0], man_s};
        if (a_nan_s || b_nan_s) begin
            y = FP16_QNAN;
        end else if (a_inf_s && b_inf_s) begin
            y = (a[15] == b[15]) ? FP16_QNAN : a;
        end else if (a_inf_s) begin
            y = a;
        end else if (b_inf_s) begin
            y = b[15] ? FP16_POS_INF : FP16_NEG_INF;
        end else if (raw_s == 15'd0) begin
            y = FP16_ZERO;
        end else if (exp_norm_s < 7'sd1) begin
            y = {big_sgn_s, 15'h0000};
        end else if (exp_rnd_s > 7'sd30) begin
            y = big_sgn_s ? FP16_NEG_INF : FP16_POS_INF;
        end else begin
            y = {big_sgn_s, exp_rnd_s[4:0], man_s};
        end
    end

endmodule

// File: rtl/fp16_sub_max64.sv
// Captures a 64-element FP16 vector, waits for its max, then streams x_i - max
// in four-lane beats. One vector in flight at a time.
module fp16_sub_max64
    import fp16_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fp16_sub_max64_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MAX = 2'd1,
        STREAM   = 2'd2
    } state_t;

    localparam int LANE_W = $clog2(VEC_LANES);

    state_t                        state_r, state_n;
    logic [VEC_N-1:0][15:0]        vec_r;
    logic [15:0]                   max_r;
    logic [VEC_LANES-1:0][15:0]    d_data_r, diff_s;
    logic [BEAT_IDX_W-1:0]         d_idx_r, beat_sel_s;
    logic                          d_last_r, x_ready_r, max_ready_r, d_valid_r;
    logic [15:0]                   sub_b_s;

    assign bus.x_ready   = x_ready_r;
    assign bus.max_ready = max_ready_r;
    assign bus.d_valid   = d_valid_r;
    assign bus.d_data    = d_data_r;
    assign bus.d_idx     = d_idx_r;
    assign bus.d_last    = d_last_r;

    // Next-state decode; handshake conditions use the registered state only.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:     if (bus.x_valid)               state_n = WAIT_MAX; else state_n = state_r;
            WAIT_MAX: if (bus.max_valid)             state_n = STREAM;   else state_n = state_r;
            STREAM:   if (bus.d_ready && d_last_r)   state_n = IDLE;     else state_n = state_r;
            default:                                 state_n = IDLE;
        endcase
    end

    // Beat 0 is computed against the incoming max; later beats against the stored one.
    always_comb begin
        beat_sel_s = {BEAT_IDX_W{1'b0}};
        sub_b_s    = max_r;
        if (state_r == WAIT_MAX) begin
            beat_sel_s = {BEAT_IDX_W{1'b0}};
            sub_b_s    = bus.max;
        end else begin
            beat_sel_s = d_idx_r + BEAT_IDX_W'(1);
            sub_b_s    = max_r;
        end
    end

    for (genvar j = 0; j < VEC_LANES; j++) begin : g_lane
        logic [ELEM_IDX_W-1:0] elem_idx_s;
        assign elem_idx_s = {beat_sel_s, LANE_W'(j)};
        fp16_sub u_sub (
            .a (vec_r[elem_idx_s]),
            .b (sub_b_s),
            .y (diff_s[j])
        );
    end

    // State, datapath and registered handshake flags; rst overrides all handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            vec_r       <= '0;
            max_r       <= 16'h0000;
            d_data_r    <= '0;
            d_idx_r     <= {BEAT_IDX_W{1'b0}};
            d_last_r    <= 1'b0;
            x_ready_r   <= 1'b1;
            max_ready_r <= 1'b0;
            d_valid_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            x_ready_r   <= (state_n == IDLE);
            max_ready_r <= (state_n == WAIT_MAX);
            d_valid_r   <= (state_n == STREAM);
            case (state_r)
                IDLE: begin
                    if (bus.x_valid) begin
                        vec_r <= bus.x;
                    end
                end
                WAIT_MAX: begin
                    if (bus.max_valid) begin
                        max_r    <= bus.max;
                        d_data_r <= diff_s;
                        d_idx_r  <= {BEAT_IDX_W{1'b0}};
                        d_last_r <= (VEC_BEATS == 1);
                    end
                end
                STREAM: begin
                    if (bus.d_ready) begin
                        if (d_last_r) begin
                            d_idx_r  <= {BEAT_IDX_W{1'b0}};
                            d_last_r <= 1'b0;
                        end else begin
                            d_data_r <= diff_s;
                            d_idx_r  <= d_idx_r + BEAT_IDX_W'(1);
                            d_last_r <= (d_idx_r == BEAT_IDX_W'(VEC_BEATS - 2));
                        end
                    end
                end
                default: begin
                    d_last_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_sub_max64.sv
// Randomized bench for fp16_sub_max64 against a real-arithmetic reference of
// binary16 subtraction with RNE and flush-to-zero.
module tb_fp16_sub_max64;
    import fp16_pkg::*;

    logic clk = 1'b0;
    logic rst;
    fp16_sub_max64_if bus();

    fp16_sub_max64 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int last_wait;
    logic [15:0] xv  [VEC_N];
    logic [15:0] obs [VEC_N];
    logic [15:0] mx;

    initial begin
        #3000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real to_real(input logic [15:0] h);
        real r;
        if (h[14:10] == 5'd0) return 0.0;
        r = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] from_real(input real v);
        logic s;
        real m, q;
        int e;
        longint fi;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        m = s ? -v : v;
        if (m < pow2(-14)) return {s, 15'h0000};
        e = -14;
        while (m >= pow2(e + 1)) e++;
        q  = m / pow2(e - 10);
        fi = longint'(q);
        if (real'(fi) > q) fi--;
        if ((q - real'(fi) > 0.5) || ((q - real'(fi) == 0.5) && (fi % 2 == 1))) fi++;
        if (fi == 2048) begin
            fi = 1024;
            e++;
        end
        if (e > 15) return {s, 15'h7C00};
        return {s, 5'(e + 15), 10'(fi - 1024)};
    endfunction

    function automatic logic [15:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
        logic a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        logic b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        logic a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        logic b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        if (a_nan || b_nan) return 16'h7E00;
        if (a_inf && b_inf) return (a[15] == b[15]) ? 16'h7E00 : a;
        if (a_inf) return a;
        if (b_inf) return {~b[15], 15'h7C00};
        return from_real(to_real(a) - to_real(b));
    endfunction

    function automatic logic [15:0] rand_fp16();
        if ($urandom_range(99) < 10) return 16'($urandom());
        return {1'($urandom()), 5'($urandom_range(20, 8)), 10'($urandom())};
    endfunction

    function automatic logic [VEC_N*16-1:0] pack_vec();
        logic [VEC_N*16-1:0] p;
        for (int i = 0; i < VEC_N; i++) p[i*16 +: 16] = xv[i];
        return p;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < VEC_N; i++) xv[i] = rand_fp16();
        mx = ($urandom_range(1) == 0) ? xv[$urandom_range(VEC_N - 1)] : rand_fp16();
    endtask

    // Sends xv then mx, consumes all beats and checks each against the model.
    task automatic run_vector(input int ready_pct, input bit hold_x, input int abort_at, input string tag);
        int beat, cyc;
        logic [15:0] e, got;
        last_wait = 0;
        while (bus.x_ready !== 1'b1 && last_wait < 40) begin
            tick();
            last_wait++;
        end
        total++;
        if (bus.x_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s x_ready_wait got=%b want=1", tag, bus.x_ready);
        end
        bus.x = pack_vec();
        bus.x_valid = 1'b1;
        tick();
        if (hold_x) bus.x = {32{$urandom()}};
        else        bus.x_valid = 1'b0;
        total++;
        if (bus.x_ready !== 1'b0 || bus.max_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s wait_max_flags got x_ready=%b max_ready=%b want 0/1", tag, bus.x_ready, bus.max_ready);
        end
        bus.max = mx;
        bus.max_valid = 1'b1;
        tick();
        bus.max_valid = 1'b0;
        total++;
        if (bus.d_valid !== 1'b1 || bus.max_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s first_beat_latency got d_valid=%b max_ready=%b want 1/0", tag, bus.d_valid, bus.max_ready);
        end
        beat = 0;
        cyc  = 0;
        while (beat < VEC_BEATS && cyc < 400) begin
            if (abort_at == beat) begin
                rst = 1'b1;
                bus.d_ready = 1'b1;
                bus.x_valid = 1'b1;
                tick();
                rst = 1'b0;
                bus.x_valid = 1'b0;
                bus.d_ready = 1'b0;
                total++;
                if (bus.d_valid !== 1'b0 || bus.max_ready !== 1'b0 || bus.x_ready !== 1'b1 || bus.d_idx !== '0) begin
                    bad++;
                    $display("FAIL %s abort_state got d_valid=%b max_ready=%b x_ready=%b d_idx=%0d want 0/0/1/0",
                             tag, bus.d_valid, bus.max_ready, bus.x_ready, bus.d_idx);
                end
                return;
            end
            bus.d_ready = ($urandom_range(99) < ready_pct);
            total++;
            if (bus.d_valid !== 1'b1 || bus.d_idx !== BEAT_IDX_W'(beat) || bus.d_last !== (beat == VEC_BEATS - 1)) begin
                bad++;
                $display("FAIL %s beat_ctrl got valid=%b idx=%0d last=%b want 1/%0d/%b",
                         tag, bus.d_valid, bus.d_idx, bus.d_last, beat, beat == VEC_BEATS - 1);
            end
            if (hold_x) begin
                total++;
                if (bus.x_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s capture_while_busy got x_ready=%b want 0", tag, bus.x_ready);
                end
            end
            for (int j = 0; j < VEC_LANES; j++) begin
                e   = ref_sub(xv[beat*VEC_LANES + j], mx);
                got = bus.d_data[j*16 +: 16];
                obs[beat*VEC_LANES + j] = got;
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s lane beat=%0d lane=%0d x=%h max=%h got=%h want=%h",
                             tag, beat, j, xv[beat*VEC_LANES + j], mx, got, e);
                end
            end
            if (bus.d_ready) beat++;
            tick();
            cyc++;
        end
        bus.d_ready = 1'b0;
        bus.x_valid = 1'b0;
        total++;
        if (beat != VEC_BEATS) begin
            bad++;
            $display("FAIL %s beat_count got=%0d want=%0d", tag, beat, VEC_BEATS);
        end
        total++;
        if (bus.x_ready !== 1'b1 || bus.d_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s return_idle got x_ready=%b d_valid=%b want 1/0", tag, bus.x_ready, bus.d_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (bus.x_ready !== 1'b1 || bus.max_ready !== 1'b0 || bus.d_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got x_ready=%b max_ready=%b d_valid=%b want 1/0/0", bus.x_ready, bus.max_ready, bus.d_valid);
        end
        total++;
        if (bus.d_last !== 1'b0 || bus.d_idx !== '0 || bus.d_data !== '0) begin
            bad++;
            $display("FAIL reset_data got d_last=%b d_idx=%0d d_data=%h want 0/0/0", bus.d_last, bus.d_idx, bus.d_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_all_equal();
        for (int i = 0; i < VEC_N; i++) xv[i] = 16'h3C00;
        mx = 16'h3C00;
        run_vector(100, 1'b0, -1, "all_equal");
        for (int i = 0; i < VEC_N; i++) begin
            total++;
            if (obs[i] !== 16'h0000) begin
                bad++;
                $display("FAIL all_equal_zero idx=%0d got=%h want=0000", i, obs[i]);
            end
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < VEC_N; i++) xv[i] = from_real(real'(i));
        mx = 16'h53E0;
        run_vector(100, 1'b0, -1, "ramp");
        total++;
        if (obs[0] !== 16'hD3E0 || obs[62] !== 16'hBC00 || obs[63] !== 16'h0000) begin
            bad++;
            $display("FAIL ramp_points got=%h/%h/%h want=d3e0/bc00/0000", obs[0], obs[62], obs[63]);
        end
    endtask

    task automatic test_round_tie();
        fill_random();
        xv[0] = 16'h3800;
        mx    = 16'h6800;
        run_vector(100, 1'b0, -1, "round_tie");
        total++;
        if (obs[0] !== 16'hE800) begin
            bad++;
            $display("FAIL round_tie got=%h want=e800", obs[0]);
        end
    endtask

    task automatic test_specials();
        fill_random();
        mx    = 16'h7C00;
        xv[0] = 16'h7C00;
        xv[1] = 16'h3C00;
        xv[2] = 16'h7E00;
        run_vector(100, 1'b0, -1, "specials_inf");
        total++;
        if (obs[0] !== 16'h7E00 || obs[1] !== 16'hFC00 || obs[2] !== 16'h7E00) begin
            bad++;
            $display("FAIL specials_inf got=%h/%h/%h want=7e00/fc00/7e00", obs[0], obs[1], obs[2]);
        end
        fill_random();
        mx    = 16'h0000;
        xv[3] = 16'h0001;
        run_vector(100, 1'b0, -1, "specials_sub");
        total++;
        if (obs[3] !== 16'h0000) begin
            bad++;
            $display("FAIL specials_subnormal got=%h want=0000", obs[3]);
        end
    endtask

    task automatic test_random();
        for (int v = 0; v < 6; v++) begin
            fill_random();
            run_vector((v % 2 == 0) ? 100 : 70, 1'b0, -1, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int v = 0; v < 3; v++) begin
            fill_random();
            run_vector(100, 1'b0, -1, "back_to_back");
            total++;
            if (last_wait != 0) begin
                bad++;
                $display("FAIL back_to_back_wait got=%0d want=0", last_wait);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int v = 0; v < 2; v++) begin
            fill_random();
            run_vector(50, 1'b1, -1, "backpressure");
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        run_vector(100, 1'b0, 5, "reset_mid");
        fill_random();
        run_vector(100, 1'b0, -1, "after_reset");
    endtask

    initial begin
        rst           = 1'b1;
        bus.x         = '0;
        bus.x_valid   = 1'b0;
        bus.max       = 16'h0000;
        bus.max_valid = 1'b0;
        bus.d_ready   = 1'b0;
        test_reset();
        test_all_equal();
        test_ramp();
        test_round_tie();
        test_specials();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp16_sub_max64.md
# fp16_sub_max64

Softmax stage directly downstream of the 64-input FP16 max tree. Captures the same 64-element FP16 vector that is broadcast to the max tree, waits for the tree's max result, then streams the differences x_i − max out in LANES-wide beats toward the exponent stage. Registered three-state controller with valid/ready handshakes on all three interfaces.

## Interface
- N, 64, elements per vector (fixed; power of two)
- LANES, 4, differences per output beat (power of two, divides N)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- x  in  N*16  input vector; element i at x[i*16 +: 16]
- x_valid  in  1  vector valid
- x_ready  out  1  block can capture a vector
- max  in  16  FP16 max of the vector, from the max tree
- max_valid  in  1  max valid
- max_ready  out  1  block accepts max
- d_data  out  LANES*16  lane j = x[(beat*LANES+j)] − max
- d_idx  out  log2(N/LANES)  beat index, 0..N/LANES−1
- d_last  out  1  high on final beat
- d_valid  out  1  beat valid
- d_ready  in  1  downstream accepts beat

## Operation
- States: IDLE, WAIT_MAX, STREAM.
- IDLE: x_ready=1. x_valid&x_ready → register full vector, go WAIT_MAX.
- WAIT_MAX: max_ready=1. max_valid&max_ready → register max, register beat 0 into d_data, go STREAM.
- STREAM: d_valid=1. d_valid&d_ready on beat k<N/LANES−1 → load beat k+1, d_idx=k+1. On final beat (d_last=1) → IDLE.
- max is never accepted in IDLE; x is never accepted outside IDLE (one vector in flight).
- Subtraction per lane: general IEEE-754 binary16 a−b, round-to-nearest-even (guard/round/sticky); correct for any sign/order, although x_i ≤ max in normal use.
- Subnormal inputs treated as zero of same sign; subnormal results flushed to signed zero (0x8000 when negative).
- Exact-zero result → 0x0000. Overflow → ±inf (0xFC00 / 0x7C00).
- Any NaN input, or inf−inf of same sign → 0x7E00. Finite − (+inf) → 0xFC00.

## Timing
- Handshake outputs decode from registered state only; no combinational input→output path.
- After a cycle with rst=1: state IDLE, x_ready=1, max_ready=0, d_valid=0, d_last=0, d_idx=0, d_data=0, vector/max registers cleared.
- Max accepted at cycle t → d_valid=1 with beat 0 at t+1.
- One beat per cycle under continuous d_ready; N/LANES=16 beats per vector.
- Last beat accepted at t → x_ready=1 at t+1. Minimum vector period: 1 (capture) + 1 (max) + 16 beats = 18 cycles.
- d_valid&!d_ready: d_data, d_idx, d_last held stable.
- rst mid-operation (any state): aborts, discards captured vector and max, no further beats from it.
- rst has priority over every simultaneous handshake.

## Structure
- Shared package fp16_pkg: FP16 field widths (sign 1, exp 5, mant 10), bias 15, constants FP16_QNAN=16'h7E00, FP16_NEG_INF=16'hFC00, FP16_POS_INF=16'h7C00, FP16_ZERO=16'h0000; state enum lives locally.
- One sub-module: fp16_sub, purely combinational a−b with RNE, instantiated LANES times on the beat slice selected by the next-beat index; result registered into d_data.

## Test plan
- All x=0x3C00, max=0x3C00, d_ready=1 → 16 beats all 0x0000, d_idx 0..15, d_last only on beat 15, x_ready=1 next cycle.
- x_i=FP16(i) for i=0..63, max=0x53E0 (63.0) → element 0 = 0xD3E0, element 62 = 0xBC00, element 63 = 0x0000.
- Rounding tie: x_0=0x3800 (0.5), max=0x6800 (2048) → lane 0 = 0xE800 (−2048, RNE to even).
- Specials: max=0x7C00; x_0=0x7C00 → 0x7E00, x_1=0x3C00 → 0xFC00, x_2=0x7E00 → 0x7E00; x_3=0x0001 (subnormal) with max=0x0000 → 0x0000.
- Backpressure: d_ready random 50% → d_data/d_idx stable while stalled, exactly 16 accepted beats, none duplicated; x_valid held high meanwhile → no capture until IDLE.
- rst at beat 5 of STREAM → next cycle d_valid=0, max_ready=0, x_ready=1; following vector processes correctly from beat 0.
